instr_sequencer: RTL and testbench

//  Multi-cycle control FSM for the 9-bit core. Owns the PC and instruction register,

---
 rtl/ctrl_pkg.sv | 29 ++
 rtl/branch_resolve.sv | 24 ++
 rtl/instr_sequencer.sv | 178 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control definitions for the 9-bit core: sequencer states, opcode
// encodings and instruction-type values used by the sequencer and the decoder.
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } seq_state_t;

    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_BEQ  = 4'b1001;
    localparam logic [3:0] OP_BLT  = 4'b1010;
    localparam logic [3:0] OP_BGT  = 4'b1011;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic ITYPE_RUN = 1'b0;
    localparam logic ITYPE_PUT = 1'b1;

    // Halt is only a run-type instruction; a put with opcode 1111 is still a put.
    function automatic logic is_halt(input logic [8:0] ir);
        return (ir[0] == ITYPE_RUN) && (ir[4:1] == OP_HALT);
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch decision from the branch opcode and the ALU compare flags.
module branch_resolve
    import ctrl_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic       i_eq,
    input  logic       i_lt,
    input  logic       i_gt,
    output logic       o_taken
);

    // Select the compare flag that qualifies each branch opcode.
    always_comb begin
        o_taken = 1'b0;
        case (i_opcode)
            OP_JMP:  o_taken = 1'b1;
            OP_BEQ:  o_taken = i_eq;
            OP_BLT:  o_taken = i_lt;
            OP_BGT:  o_taken = i_gt;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: owns PC and IR, gates the
// decoder's write requests, resolves branches, bounds memory waits, counts cycles.
module instr_sequencer
    import ctrl_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int MEM_TIMEOUT = 16,
    parameter int CYC_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [8:0]       instr_i,
    input  logic             branch_flag,
    input  logic             mem_to_reg_flag,
    input  logic             mem_write_flag,
    input  logic             reg_write_flag,
    input  logic             put_flag,
    input  logic             alu_eq,
    input  logic             alu_lt,
    input  logic             alu_gt,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             mem_ready,
    output logic [PC_W-1:0]  pc_o,
    output logic [8:0]       ir_o,
    output logic             alu_en,
    output logic             reg_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic             put_en,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [CYC_W-1:0] cycle_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    seq_state_t        r_state, w_state_nx;
    logic [PC_W-1:0]   r_pc, w_pc_nx, w_pc_inc;
    logic [8:0]        r_ir, w_ir_nx;
    logic [WAIT_W-1:0] r_wait, w_wait_nx;
    logic [CYC_W-1:0]  r_cnt, w_cnt_nx;
    logic              r_done, w_done_nx;
    logic              r_fault, w_fault_nx;
    logic              w_taken;
    logic              w_busy;

    branch_resolve u_branch_resolve (
        .i_opcode (r_ir[4:1]),
        .i_eq     (alu_eq),
        .i_lt     (alu_lt),
        .i_gt     (alu_gt),
        .o_taken  (w_taken)
    );

    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_busy   = (r_state != IDLE) && (r_state != HALT);

    // Sequencer state register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_ir    <= 9'd0;
            r_wait  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_ir    <= w_ir_nx;
            r_wait  <= w_wait_nx;
            r_cnt   <= w_cnt_nx;
            r_done  <= w_done_nx;
            r_fault <= w_fault_nx;
        end
    end

    // Next-state, register updates and the combinational strobes.
    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_ir_nx    = r_ir;
        w_wait_nx  = r_wait;
        w_done_nx  = r_done;
        w_fault_nx = r_fault;
        alu_en     = 1'b0;
        reg_we     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        put_en     = 1'b0;

        if (w_busy && (r_cnt != {CYC_W{1'b1}})) begin
            w_cnt_nx = r_cnt + CYC_W'(1);
        end else begin
            w_cnt_nx = r_cnt;
        end

        case (r_state)
            IDLE, HALT: begin
                if (start) begin
                    w_state_nx = FETCH;
                    w_pc_nx    = '0;
                    w_cnt_nx   = '0;
                    w_done_nx  = 1'b0;
                    w_fault_nx = 1'b0;
                end else begin
                    w_state_nx = r_state;
                end
            end
            FETCH: begin
                w_ir_nx    = instr_i;
                w_state_nx = DECODE;
            end
            DECODE: begin
                if (is_halt(r_ir)) begin
                    w_state_nx = HALT;
                    w_done_nx  = 1'b1;
                end else begin
                    w_state_nx = EXEC;
                end
            end
            EXEC: begin
                if (put_flag) begin
                    put_en     = 1'b1;
                    w_pc_nx    = w_pc_inc;
                    w_state_nx = FETCH;
                end else if (branch_flag) begin
                    w_pc_nx    = w_taken ? branch_target : w_pc_inc;
                    w_state_nx = FETCH;
                end else if (mem_to_reg_flag || mem_write_flag) begin
                    w_wait_nx  = '0;
                    w_state_nx = MEM;
                end else begin
                    alu_en     = 1'b1;
                    w_state_nx = WB;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = mem_write_flag;
                if (mem_ready) begin
                    if (mem_to_reg_flag) begin
                        w_state_nx = WB;
                    end else begin
                        w_pc_nx    = w_pc_inc;
                        w_state_nx = FETCH;
                    end
                end else if (r_wait == WAIT_LAST) begin
                    // Out of patience: give up the request and park with a fault.
                    w_state_nx = HALT;
                    w_fault_nx = 1'b1;
                end else begin
                    w_wait_nx = r_wait + WAIT_W'(1);
                end
            end
            WB: begin
                reg_we     = reg_write_flag;
                w_pc_nx    = w_pc_inc;
                w_state_nx = FETCH;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign pc_o      = r_pc;
    assign ir_o      = r_ir;
    assign busy      = w_busy;
    assign done      = r_done;
    assign fault     = r_fault;
    assign cycle_cnt = r_cnt;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: ROM model and decoder model drive the
// sequencer; expected write-strobe PCs are queued and matched when strobes fire.
module tb_instr_sequencer;

    localparam logic [8:0] I_ADD   = 9'h000;
    localparam logic [8:0] I_LOAD  = 9'h002;
    localparam logic [8:0] I_STORE = 9'h004;
    localparam logic [8:0] I_PUT   = 9'h001;
    localparam logic [8:0] I_JMP   = 9'h010;
    localparam logic [8:0] I_BEQ   = 9'h012;
    localparam logic [8:0] I_BLT   = 9'h014;
    localparam logic [8:0] I_BGT   = 9'h016;
    localparam logic [8:0] I_HALT  = 9'h01E;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start4 = 1'b0;
    logic        alu_eq = 1'b0, alu_lt = 1'b0, alu_gt = 1'b0;
    logic [7:0]  branch_target = 8'h00;
    logic        mem_ready = 1'b0;
    logic [8:0]  rom [0:255];

    logic [7:0]  pc_o;
    logic [8:0]  ir_o, instr_i;
    logic        alu_en, reg_we, mem_req, mem_we, put_en, busy, done, fault;
    logic [15:0] cycle_cnt;
    logic [4:0]  fl;

    logic [3:0]  pc4;
    logic [8:0]  ir4;
    logic        alu_en4, reg_we4, mem_req4, mem_we4, put_en4, busy4, done4, fault4;
    logic [3:0]  cnt4;
    logic [4:0]  fl4;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_we_q[$];
    logic [7:0] exp_put_q[$];

    always #5 clk = ~clk;

    // Bench decoder: {branch, mem_to_reg, mem_write, reg_write, put}.
    function automatic logic [4:0] dec(input logic [8:0] ir);
        if (ir[0]) return 5'b00001;
        case (ir[4:1])
            4'b1000, 4'b1001, 4'b1010, 4'b1011: return 5'b10000;
            4'b0001: return 5'b01010;
            4'b0010: return 5'b00100;
            4'b1111: return 5'b00000;
            default: return 5'b00010;
        endcase
    endfunction

    assign instr_i = rom[pc_o];
    assign fl  = dec(ir_o);
    assign fl4 = dec(ir4);

    instr_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr_i(instr_i),
        .branch_flag(fl[4]), .mem_to_reg_flag(fl[3]), .mem_write_flag(fl[2]),
        .reg_write_flag(fl[1]), .put_flag(fl[0]),
        .alu_eq(alu_eq), .alu_lt(alu_lt), .alu_gt(alu_gt),
        .branch_target(branch_target), .mem_ready(mem_ready),
        .pc_o(pc_o), .ir_o(ir_o), .alu_en(alu_en), .reg_we(reg_we),
        .mem_req(mem_req), .mem_we(mem_we), .put_en(put_en), .busy(busy),
        .done(done), .fault(fault), .cycle_cnt(cycle_cnt)
    );

    instr_sequencer #(.PC_W(4), .MEM_TIMEOUT(16), .CYC_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .instr_i(I_ADD),
        .branch_flag(fl4[4]), .mem_to_reg_flag(fl4[3]), .mem_write_flag(fl4[2]),
        .reg_write_flag(fl4[1]), .put_flag(fl4[0]),
        .alu_eq(1'b0), .alu_lt(1'b0), .alu_gt(1'b0),
        .branch_target(4'h0), .mem_ready(1'b0),
        .pc_o(pc4), .ir_o(ir4), .alu_en(alu_en4), .reg_we(reg_we4),
        .mem_req(mem_req4), .mem_we(mem_we4), .put_en(put_en4), .busy(busy4),
        .done(done4), .fault(fault4), .cycle_cnt(cnt4)
    );

    // Scoreboard: every reg_we / put_en strobe must match the next queued PC.
    always @(negedge clk) begin
        if (rst_n && reg_we) begin
            checks++;
            if (exp_we_q.size() == 0) begin
                failures++;
                $display("FAIL sb_reg_we: unexpected strobe at pc=%0h, required none", pc_o);
            end else begin
                logic [7:0] e;
                e = exp_we_q.pop_front();
                if (pc_o !== e) begin
                    failures++;
                    $display("FAIL sb_reg_we_pc: got %0h required %0h", pc_o, e);
                end
            end
        end
        if (rst_n && put_en) begin
            checks++;
            if (exp_put_q.size() == 0) begin
                failures++;
                $display("FAIL sb_put_en: unexpected strobe at pc=%0h, required none", pc_o);
            end else begin
                logic [7:0] e;
                e = exp_put_q.pop_front();
                if (pc_o !== e) begin
                    failures++;
                    $display("FAIL sb_put_pc: got %0h required %0h", pc_o, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = I_HALT;
    endtask

    task automatic wait_halt(input int limit);
        int n;
        n = 0;
        while (busy === 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL halt_timeout: busy=%b after %0d cycles, required 0", busy, limit);
        end
    endtask

    // Drives mem_ready in the ready_after-th MEM cycle; returns MEM cycles seen.
    task automatic run_mem(input int ready_after, output int req_cnt, output logic we_seen);
        req_cnt = 0;
        we_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (mem_req === 1'b1) begin
                req_cnt++;
                we_seen = we_seen | mem_we;
                mem_ready = (req_cnt >= ready_after);
            end else if (req_cnt != 0) begin
                break;
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({pc_o, ir_o, cycle_cnt} !== 33'd0) begin
            failures++;
            $display("FAIL reset_regs: pc=%0h ir=%0h cnt=%0d required 0/0/0", pc_o, ir_o, cycle_cnt);
        end
        checks++;
        if ({alu_en, reg_we, mem_req, mem_we, put_en, busy, done, fault} !== 8'd0) begin
            failures++;
            $display("FAIL reset_flags: got %b required 00000000",
                     {alu_en, reg_we, mem_req, mem_we, put_en, busy, done, fault});
        end
    endtask

    task automatic test_add_halt();
        clear_rom();
        rom[0] = I_ADD;
        exp_we_q.push_back(8'h00);
        do_start();
        tick(2);
        checks++;
        if (alu_en !== 1'b1) begin
            failures++;
            $display("FAIL add_alu_en: got %b required 1 in cycle 3", alu_en);
        end
        tick(1);
        checks++;
        if (reg_we !== 1'b1) begin
            failures++;
            $display("FAIL add_reg_we: got %b required 1 in cycle 4", reg_we);
        end
        tick(3);
        checks++;
        if ({done, fault, busy} !== 3'b100 || cycle_cnt !== 16'd6 || pc_o !== 8'h01) begin
            failures++;
            $display("FAIL add_halt: done/fault/busy=%b cnt=%0d pc=%0h required 100/6/1",
                     {done, fault, busy}, cycle_cnt, pc_o);
        end
    endtask

    task automatic test_branch_table();
        logic [8:0] ops [7] = '{I_JMP, I_BEQ, I_BEQ, I_BLT, I_BLT, I_BGT, I_BGT};
        logic [2:0] elg [7] = '{3'b000, 3'b100, 3'b011, 3'b010, 3'b101, 3'b001, 3'b110};
        logic       tk  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            clear_rom();
            rom[0] = ops[i];
            {alu_eq, alu_lt, alu_gt} = elg[i];
            branch_target = 8'h20;
            do_start();
            wait_halt(20);
            checks++;
            if (pc_o !== (tk[i] ? 8'h20 : 8'h01) || done !== 1'b1) begin
                failures++;
                $display("FAIL branch_%0d: pc=%0h done=%b required %0h/1",
                         i, pc_o, done, tk[i] ? 8'h20 : 8'h01);
            end
        end
        {alu_eq, alu_lt, alu_gt} = 3'b000;
    endtask

    task automatic test_beq_pc3();
        for (int r = 0; r < 2; r++) begin
            clear_rom();
            rom[0] = I_PUT; rom[1] = I_PUT; rom[2] = I_PUT; rom[3] = I_BEQ;
            for (int k = 0; k < 3; k++) exp_put_q.push_back(k[7:0]);
            alu_eq = (r == 0);
            branch_target = 8'h20;
            do_start();
            wait_halt(40);
            checks++;
            if (pc_o !== ((r == 0) ? 8'h20 : 8'h04)) begin
                failures++;
                $display("FAIL beq_pc3_%0d: pc=%0h required %0h", r, pc_o, (r == 0) ? 8'h20 : 8'h04);
            end
        end
        alu_eq = 1'b0;
    endtask

    task automatic test_load_wait();
        int   n;
        logic we;
        clear_rom();
        rom[0] = I_LOAD;
        exp_we_q.push_back(8'h00);
        do_start();
        run_mem(4, n, we);
        checks++;
        if (n != 4 || we !== 1'b0 || reg_we !== 1'b1) begin
            failures++;
            $display("FAIL load_wait: req_cycles=%0d mem_we=%b reg_we=%b required 4/0/1", n, we, reg_we);
        end
        tick(1);
        checks++;
        if (pc_o !== 8'h01 || reg_we !== 1'b0) begin
            failures++;
            $display("FAIL load_pc: pc=%0h reg_we=%b required 1/0", pc_o, reg_we);
        end
        wait_halt(20);
    endtask

    task automatic test_store(input int ready_after, input int exp_n, input logic exp_fault);
        int   n;
        logic we;
        clear_rom();
        rom[0] = I_STORE;
        do_start();
        run_mem(ready_after, n, we);
        if (!exp_fault) wait_halt(20);
        checks++;
        if (n != exp_n || we !== 1'b1 || fault !== exp_fault || done !== !exp_fault ||
            mem_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL store_%0d: req_cycles=%0d we=%b fault=%b done=%b req=%b busy=%b required %0d/1/%b/%b/0/0",
                     ready_after, n, we, fault, done, mem_req, busy, exp_n, exp_fault, !exp_fault);
        end
        checks++;
        if (pc_o !== (exp_fault ? 8'h00 : 8'h01)) begin
            failures++;
            $display("FAIL store_pc_%0d: pc=%0h required %0h", ready_after, pc_o, exp_fault ? 8'h00 : 8'h01);
        end
    endtask

    task automatic test_reset_mid_mem();
        int n;
        clear_rom();
        rom[0] = I_PUT; rom[1] = I_LOAD;
        exp_put_q.push_back(8'h00);
        do_start();
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        checks++;
        if (mem_req !== 1'b1 || pc_o !== 8'h01) begin
            failures++;
            $display("FAIL mid_mem_reach: mem_req=%b pc=%0h required 1/1", mem_req, pc_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || pc_o !== 8'h00 || busy !== 1'b0 || ir_o !== 9'd0 || cycle_cnt !== 16'd0) begin
            failures++;
            $display("FAIL mid_mem_reset: req=%b pc=%0h busy=%b ir=%0h cnt=%0d required 0/0/0/0/0",
                     mem_req, pc_o, busy, ir_o, cycle_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_wrap_busy();
        start4 = 1'b1;
        tick(1);
        start4 = 1'b0;
        tick(4);
        start4 = 1'b1;
        tick(1);
        start4 = 1'b0;
        checks++;
        if (pc4 !== 4'd1 || busy4 !== 1'b1) begin
            failures++;
            $display("FAIL busy_start: pc=%0d busy=%b required 1/1", pc4, busy4);
        end
        tick(55);
        checks++;
        if (pc4 !== 4'd15) begin
            failures++;
            $display("FAIL wrap_pre: pc=%0d required 15", pc4);
        end
        tick(4);
        checks++;
        if (pc4 !== 4'd0 || fault4 !== 1'b0 || done4 !== 1'b0 || busy4 !== 1'b1 || cnt4 !== 4'hF) begin
            failures++;
            $display("FAIL wrap_post: pc=%0d fault=%b done=%b busy=%b cnt=%0d required 0/0/0/1/15",
                     pc4, fault4, done4, busy4, cnt4);
        end
    endtask

    initial begin
        clear_rom();
        tick(3);
        test_reset();
        rst_n = 1'b1;
        tick(2);
        test_add_halt();
        test_branch_table();
        test_beq_pc3();
        test_load_wait();
        test_store(1, 1, 1'b0);
        test_store(1000, 16, 1'b1);
        test_reset_mid_mem();
        test_wrap_busy();
        checks++;
        if (exp_we_q.size() != 0 || exp_put_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: reg_we left=%0d put left=%0d required 0/0",
                     exp_we_q.size(), exp_put_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
